// File: rtl/matrix_display_pkg.sv
// Shared types, MAX7219 register map and word builders for the matrix display path.
package matrix_display_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_SEND = 3'd2,
    ST_HOLD = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  localparam logic [3:0] DIGIT0   = 4'h1;
  localparam logic [3:0] DECODE   = 4'h9;
  localparam logic [3:0] INTENS   = 4'hA;
  localparam logic [3:0] SCANLIM  = 4'hB;
  localparam logic [3:0] SHUTDN   = 4'hC;
  localparam logic [3:0] DISPTEST = 4'hF;

  localparam int WORD_W = 16;

  function automatic logic [WORD_W-1:0] init_word(input logic [2:0] idx,
                                                  input logic [3:0] intensity);
    logic [WORD_W-1:0] w;
    case (idx)
      3'd0:    w = {4'h0, DISPTEST, 8'h00};
      3'd1:    w = {4'h0, DECODE, 8'h00};
      3'd2:    w = {4'h0, INTENS, 4'h0, intensity};
      3'd3:    w = {4'h0, SCANLIM, 8'h07};
      default: w = {4'h0, SHUTDN, 8'h01};
    endcase
    return w;
  endfunction

  // Data bit i is column i of the requested row, so column 7 leaves the wire first.
  function automatic logic [WORD_W-1:0] row_word(input logic [63:0] m,
                                                 input logic [2:0]  r);
    logic [7:0] data;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      data[i] = m[i*8 + int'(r)];
    end
    return {4'h0, DIGIT0 + {1'b0, r}, data};
  endfunction

endpackage

// File: rtl/matrix_display_spi_word_tx.sv
// Mode-0 SPI transmitter for one 16-bit word: cs low for 32*CLK_DIV cycles, then a 2*CLK_DIV cs-high gap.
// done_o marks the final gap cycle; a start seen then chains the next word with no idle cycle.
module spi_word_tx
  import matrix_display_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_GAP   = 2'd2;

  logic [1:0]        st_q, st_d;
  logic [DW-1:0]     div_q, div_d;
  logic              half_q, half_d;
  logic [3:0]        bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);
  assign done_o  = (st_q == TX_GAP) && half_q && div_end;
  assign ready_o = (st_q == TX_IDLE) || done_o;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign mosi_o  = mosi_q;

  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    half_d = half_q;
    bit_d  = bit_q;
    word_d = word_q;
    cs_d   = cs_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    case (st_q)
      TX_SHIFT: begin
        if (!div_end) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!half_q) begin
            sclk_d = 1'b1;
            half_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sclk_d = 1'b0;
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            half_d = 1'b0;
            st_d   = TX_GAP;
          end else begin
            sclk_d = 1'b0;
            half_d = 1'b0;
            bit_d  = bit_q - 4'd1;
            mosi_d = word_q[bit_q - 4'd1];
          end
        end
      end
      // The gap reuses the half-period divider twice so its counter stays CLK_DIV wide.
      TX_GAP: begin
        if (!div_end) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            st_d = TX_IDLE;
          end
        end
      end
      default: ;
    endcase
    if (ready_o && start_i) begin
      st_d   = TX_SHIFT;
      word_d = word_i;
      bit_d  = 4'd15;
      div_d  = '0;
      half_d = 1'b0;
      cs_d   = 1'b0;
      sclk_d = 1'b0;
      mosi_d = word_i[WORD_W-1];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q   <= TX_IDLE;
      div_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= 4'd0;
      word_q <= '0;
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      half_q <= half_d;
      bit_q  <= bit_d;
      word_q <= word_d;
      cs_q   <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

endmodule

// File: rtl/matrix_display.sv
// Latches the playfield on d_act_i, streams it row by row to a MAX7219, then pulses e_act_o.
// The driver init sequence is replayed after every reset; only gs=8 (one driver) is supported.
module matrix_display
  import matrix_display_pkg::*;
#(
  parameter int          gs         = 8,
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FRAME_WAIT = 24'd0,
  parameter logic [3:0]  INTENSITY  = 4'h8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [gs*gs-1:0] matrix_i,
  input  logic             d_act_i,
  output logic             e_act_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             busy_o
);

  localparam logic [23:0] HOLD_LAST = FRAME_WAIT - 24'd1;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [gs*gs-1:0]  shadow_q, shadow_d;
  logic [23:0]       hold_q, hold_d;
  logic              e_act_q;
  logic              busy_q;
  logic              tx_start;
  logic [WORD_W-1:0] tx_word;
  logic              tx_ready;
  logic              tx_done;

  spi_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (tx_start),
    .word_i  (tx_word),
    .ready_o (tx_ready),
    .done_o  (tx_done),
    .cs_o    (cs_o),
    .sclk_o  (sclk_o),
    .mosi_o  (mosi_o)
  );

  assign e_act_o = e_act_q;
  assign busy_o  = busy_q;

  // Words are issued in the transmitter's done cycle so consecutive words abut exactly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    hold_d   = hold_q;
    tx_start = 1'b0;
    tx_word  = '0;
    case (state_q)
      ST_INIT: begin
        if (tx_ready) begin
          if (!tx_done) begin
            tx_start = 1'b1;
            tx_word  = init_word(idx_q, INTENSITY);
          end else if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + 3'd1;
            tx_start = 1'b1;
            tx_word  = init_word(idx_q + 3'd1, INTENSITY);
          end
        end
      end
      ST_IDLE: begin
        if (d_act_i && tx_ready) begin
          shadow_d = matrix_i;
          idx_d    = 3'd0;
          tx_start = 1'b1;
          tx_word  = row_word(matrix_i, 3'd0);
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          if (idx_q == 3'd7) begin
            hold_d = 24'd0;
            if (FRAME_WAIT == 24'd0) begin
              state_d = ST_ACK;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            idx_d    = idx_q + 3'd1;
            tx_start = 1'b1;
            tx_word  = row_word(shadow_q, idx_q + 3'd1);
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_ACK;
        end else begin
          hold_d = hold_q + 24'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_INIT;
      idx_q    <= 3'd0;
      shadow_q <= '0;
      hold_q   <= 24'd0;
      e_act_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      hold_q   <= hold_d;
      e_act_q  <= (state_d == ST_ACK);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_matrix_display.sv
// Scoreboard bench: stimulus queues expected SPI words and e_act_o cycles, a monitor decodes the wire and compares.
module tb_matrix_display;

  localparam int CLK_DIV   = 2;
  localparam int FW        = 10;
  localparam int WORD_CYC  = 34 * CLK_DIV;
  localparam int FRAME_CYC = 8 * WORD_CYC;

  logic        clk      = 1'b0;
  logic        reset_i  = 1'b0;
  logic        d_act_i  = 1'b0;
  logic [63:0] matrix_i = '0;
  logic        e_act_o, cs_o, sclk_o, mosi_o, busy_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] exp_q[$];
  int          eact_q[$];

  int          cs_falls      = 0;
  int          last_fall_cyc = 0;
  int          nbits         = 0;
  int          low_cnt       = 0;
  logic        prev_cs       = 1'b1;
  logic        prev_sclk     = 1'b0;
  logic [15:0] shreg         = '0;

  matrix_display #(
    .gs(8), .CLK_DIV(CLK_DIV), .FRAME_WAIT(24'(FW)), .INTENSITY(4'h8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .matrix_i(matrix_i), .d_act_i(d_act_i),
    .e_act_o(e_act_o), .cs_o(cs_o), .sclk_o(sclk_o), .mosi_o(mosi_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row word from the driver's point of view: address row+1 in the high byte, column c at bit c.
  function automatic logic [15:0] model_row(input logic [63:0] m, input int r);
    int data = 0;
    for (int c = 0; c < 8; c++) begin
      if (m[c*8 + r]) data += (1 << c);
    end
    return 16'((r + 1) * 256 + data);
  endfunction

  task automatic push_frame(input logic [63:0] m, input int latch);
    for (int r = 0; r < 8; r++) exp_q.push_back(model_row(m, r));
    eact_q.push_back(latch + FRAME_CYC + FW);
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0C01);
  endtask

  // SPI/e_act monitor
  always @(negedge clk) begin
    if (reset_i) begin
      shreg     = '0;
      nbits     = 0;
      low_cnt   = 0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_cs && !cs_o) begin
        cs_falls++;
        last_fall_cyc = cyc;
        nbits   = 0;
        low_cnt = 0;
      end
      if (!cs_o) low_cnt++;
      if (!prev_sclk && sclk_o && !cs_o) begin
        shreg = {shreg[14:0], mosi_o};
        nbits++;
      end
      if (!prev_cs && cs_o) begin
        check("spi_bits", nbits, 16);
        check("spi_cs_low_len", low_cnt, 32 * CLK_DIV);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_unexpected_word: got 0x%04h expected no word", shreg);
        end else begin
          check("spi_word", int'(shreg), int'(exp_q.pop_front()));
        end
      end
      if (e_act_o) begin
        if (eact_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL eact_unexpected: got pulse at %0d expected none", cyc);
        end else begin
          check("eact_cycle", cyc, eact_q.pop_front());
        end
      end
      prev_cs   = cs_o;
      prev_sclk = sclk_o;
    end
  end

  task automatic wait_idle(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (!busy_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy_o=1 expected 0 within %0d cycles", bound);
    end
  endtask

  task automatic wait_eact(output int at, input int bound);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      @(negedge clk);
      if (e_act_o) at = cyc;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_eact_timeout: got no pulse expected one within %0d cycles", bound);
    end
  endtask

  // Called at a negedge while busy_o is low: the next edge is the latch edge.
  task automatic start_from_idle(input logic [63:0] m, output int latch);
    matrix_i = m;
    d_act_i  = 1'b1;
    latch    = cyc + 1;
    push_frame(m, latch);
    @(negedge clk);
    d_act_i = 1'b0;
  endtask

  task automatic run_init(input string tag);
    int f0, rel;
    push_init();
    f0  = cs_falls;
    rel = cyc;
    reset_i = 1'b0;
    wait_idle(2000);
    check({tag, "_word_count"}, cs_falls - f0, 5);
    check({tag, "_busy_fall"}, cyc - (rel + 1), 5 * WORD_CYC);
    check({tag, "_eact_low"}, int'(e_act_o), 0);
  endtask

  initial begin
    int          lat, e, e2, prev_e, f0;
    logic [63:0] m;
    logic [63:0] ones;

    ones = '1;
    #1 reset_i = 1'b1;
    @(negedge clk);
    check("rst_cs", int'(cs_o), 1);
    check("rst_sclk", int'(sclk_o), 0);
    check("rst_mosi", int'(mosi_o), 0);
    check("rst_eact", int'(e_act_o), 0);
    check("rst_busy", int'(busy_o), 1);
    @(negedge clk);
    run_init("init");

    // No request for 1000 cycles
    f0 = cs_falls;
    repeat (1000) @(negedge clk);
    check("idle_no_cs", cs_falls - f0, 0);
    check("idle_busy", int'(busy_o), 0);

    // Diagonal frame
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 + i] = 1'b1;
    start_from_idle(m, lat);
    @(negedge clk);
    check("diag_first_cs_fall", last_fall_cyc, lat);
    wait_eact(e, 2000);
    check("diag_eact_latency", e - lat, FRAME_CYC + FW);

    // Shadow must ignore matrix/d_act activity during SEND
    wait_idle(100);
    m = 64'd1 << 56;
    start_from_idle(m, lat);
    repeat (150) begin
      @(negedge clk);
      matrix_i = ones;
      d_act_i  = 1'($urandom_range(0, 1));
    end
    d_act_i = 1'b0;
    wait_eact(e, 2000);
    d_act_i = 1'b1;
    push_frame(ones, e + 2);
    repeat (2) @(negedge clk);
    d_act_i = 1'b0;
    wait_eact(e2, 2000);
    check("stable_next_frame_gap", e2 - e, FRAME_CYC + FW + 2);

    // Random frames with noise on the inputs while sending
    for (int k = 0; k < 3; k++) begin
      wait_idle(100);
      m = {$urandom, $urandom};
      start_from_idle(m, lat);
      repeat (200) begin
        @(negedge clk);
        matrix_i = {$urandom, $urandom};
        d_act_i  = 1'($urandom_range(0, 1));
      end
      d_act_i = 1'b0;
      wait_eact(e, 2000);
    end

    // Reset during bit 5 of row 3, then full re-init and a frame
    wait_idle(100);
    f0 = cs_falls;
    start_from_idle({$urandom, $urandom}, lat);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (cs_falls == f0 + 4 && nbits == 10) hit = 1'b1;
      end
      check("reset_point_reached", int'(hit), 1);
    end
    #2 reset_i = 1'b1;
    #1;
    check("midrst_cs", int'(cs_o), 1);
    check("midrst_sclk", int'(sclk_o), 0);
    check("midrst_eact", int'(e_act_o), 0);
    check("midrst_busy", int'(busy_o), 1);
    exp_q.delete();
    eact_q.delete();
    repeat (3) @(negedge clk);
    run_init("reinit");
    start_from_idle({$urandom, $urandom}, lat);
    wait_eact(e, 2000);
    check("resume_eact_latency", e - lat, FRAME_CYC + FW);

    // Back-to-back: d_act held high, matrix advances on each pulse
    wait_idle(100);
    m = {$urandom, $urandom};
    matrix_i = m;
    d_act_i  = 1'b1;
    push_frame(m, cyc + 1);
    prev_e = 0;
    for (int k = 0; k < 4; k++) begin
      wait_eact(e, 2000);
      if (k > 0) check("b2b_period", e - prev_e, FRAME_CYC + FW + 2);
      prev_e = e;
      if (k < 3) begin
        m = {$urandom, $urandom};
        matrix_i = m;
        push_frame(m, e + 2);
      end else begin
        d_act_i = 1'b0;
      end
    end

    begin
      bit drained = 1'b0;
      for (int i = 0; i < 200 && !drained; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0 && eact_q.size() == 0) drained = 1'b1;
      end
    end
    check("words_left", exp_q.size(), 0);
    check("eact_left", eact_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
